// File: rtl/sgd_x_fifo_drain_to_host_pkg.sv
// Shared constants, state encoding and helpers for the model-x drain path.
// Contents:
//   ENGINE_NUM, NUM_BITS_PER_BANK  engine count and bank width
//   DATA_WIDTH, BEATS_PER_EN      beat geometry (4 x 512b per engine per row)
//   FEAT_PER_ROW                  features covered by one row of all engines
//   BYTES_PER_ROW                 host bytes produced by one row
//   drain_state_t                 one-hot FSM encoding
//   rows_of()                     ceil(dimension / FEAT_PER_ROW)
package sgd_x_fifo_drain_to_host_pkg;

  localparam int ENGINE_NUM        = 8;
  localparam int NUM_BITS_PER_BANK = 64;
  localparam int DATA_WIDTH        = 512;
  localparam int BEATS_PER_EN      = 4;
  localparam int FEAT_PER_ROW      = ENGINE_NUM * NUM_BITS_PER_BANK;
  localparam int ENG_W             = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int BEAT_W            = 2;

  localparam logic [31:0] BYTES_PER_ROW = 32'(ENGINE_NUM * BEATS_PER_EN * DATA_WIDTH / 8);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_EPOCH = 5'b00010,
    S_CMD   = 5'b00100,
    S_DATA  = 5'b01000,
    S_END   = 5'b10000
  } drain_state_t;

  // 33b sum so a dimension near 2^32 does not wrap before the shift.
  function automatic logic [31:0] rows_of(input logic [31:0] dim);
    logic [32:0] s;
    s = {1'b0, dim} + 33'd511;
    return 32'(s >> 9);
  endfunction

endpackage

// File: rtl/sgd_x_fifo_drain_to_host_cursor.sv
// Beat / engine / row cursor for the drain stream.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           return all counters to 0 (held while idle)
//   advance         one beat was read this cycle
//   rows            rows per epoch for the current job
//   eng, beat       engine and beat the next read targets
//   last_in_epoch   the current position is the final beat of the epoch
module sgd_drain_cursor
  import sgd_x_fifo_drain_to_host_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [31:0]       rows,
  output logic [ENG_W-1:0]  eng,
  output logic [BEAT_W-1:0] beat,
  output logic              last_in_epoch
);

  logic [31:0] row;
  logic        last_beat;
  logic        last_eng;
  logic        last_row;

  assign last_beat = (beat == BEAT_W'(BEATS_PER_EN - 1));
  assign last_eng  = (eng == ENG_W'(ENGINE_NUM - 1));
  // >= rather than == so a row count left over from an aborted job cannot run away.
  assign last_row  = (row >= rows - 32'd1);
  assign last_in_epoch = last_beat & last_eng & last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      eng  <= '0;
      row  <= '0;
    end else if (clear) begin
      beat <= '0;
      eng  <= '0;
      row  <= '0;
    end else if (advance) begin
      if (last_beat) begin
        beat <= '0;
        if (last_eng) begin
          eng <= '0;
          row <= last_row ? 32'd0 : row + 32'd1;
        end else begin
          eng <= eng + ENG_W'(1);
        end
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sgd_x_fifo_drain_to_host.sv
// Drains the per-engine model-x FIFOs to the host DMA write port, one
// host-write command per epoch followed by that epoch's beats in
// row -> engine -> beat order.
// Ports:
//   clk, rst_n                      DMA clock, async active-low reset
//   started                         job level; addr_model/dimension/numEpochs valid while high
//   addr_model, dimension, numEpochs job parameters
//   x_to_mem_rd_data/_empty/_rd_en  per-engine FIFO read side (read latency 1)
//   x_data_send_back_start/addr/length  one-cycle host-write command
//   x_data_out, x_data_out_valid    beat stream
//   x_data_out_almost_full          downstream backpressure
//   epochs_sent                     completed epochs of the current job
//   state_dbg                       current FSM state
// Stream handshake: a beat is transferred in every cycle x_data_out_valid is
// high; there is no ready. The sink raises x_data_out_almost_full with at
// least 2 beats of margin left, since up to 2 beats still leave after it rises.
module sgd_x_fifo_drain_to_host
  import sgd_x_fifo_drain_to_host_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           started,
  input  logic [63:0]                    addr_model,
  input  logic [31:0]                    dimension,
  input  logic [31:0]                    numEpochs,
  input  logic [ENGINE_NUM*DATA_WIDTH-1:0] x_to_mem_rd_data,
  input  logic [ENGINE_NUM-1:0]          x_to_mem_empty,
  output logic [ENGINE_NUM-1:0]          x_to_mem_rd_en,
  output logic                           x_data_send_back_start,
  output logic [63:0]                    x_data_send_back_addr,
  output logic [31:0]                    x_data_send_back_length,
  output logic [DATA_WIDTH-1:0]          x_data_out,
  output logic                           x_data_out_valid,
  input  logic                           x_data_out_almost_full,
  output logic [31:0]                    epochs_sent,
  output drain_state_t                   state_dbg
);

  drain_state_t      state, state_next;
  logic [31:0]       rows_r;
  logic [31:0]       epoch_bytes_r;
  logic [63:0]       next_addr;
  logic [31:0]       epoch_idx;
  logic              almost_full_r;
  logic              rd_en_d1;
  logic [ENG_W-1:0]  eng_d1;
  logic [ENG_W-1:0]  eng;
  logic [BEAT_W-1:0] beat;
  logic              last_in_epoch;
  logic              can_read;

  assign state_dbg = state;

  // Reads stay on the current engine: an empty FIFO there stalls the stream.
  assign can_read = (state == S_DATA) & ~x_to_mem_empty[eng] & ~almost_full_r;

  sgd_drain_cursor u_cursor (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (state == S_IDLE),
    .advance       (can_read),
    .rows          (rows_r),
    .eng           (eng),
    .beat          (beat),
    .last_in_epoch (last_in_epoch)
  );

  always_comb begin
    x_to_mem_rd_en = '0;
    if (can_read) x_to_mem_rd_en[eng] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (started) state_next = S_EPOCH;
      S_EPOCH: begin
        if ((epoch_idx == numEpochs) || (rows_r == 32'd0)) state_next = S_END;
        else if (!x_to_mem_empty[0])                       state_next = S_CMD;
      end
      S_CMD:   state_next = S_DATA;
      S_DATA:  if (can_read && last_in_epoch) state_next = S_EPOCH;
      S_END:   if (!started) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Job parameters, command path and epoch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_r                  <= '0;
      epoch_bytes_r           <= '0;
      next_addr               <= '0;
      epoch_idx               <= '0;
      epochs_sent             <= '0;
      x_data_send_back_start  <= 1'b0;
      x_data_send_back_addr   <= '0;
      x_data_send_back_length <= '0;
    end else begin
      if (state == S_IDLE && started) begin
        rows_r        <= rows_of(dimension);
        epoch_bytes_r <= rows_of(dimension) * BYTES_PER_ROW;
        next_addr     <= addr_model;
        epoch_idx     <= '0;
        epochs_sent   <= '0;
      end
      x_data_send_back_start <= (state == S_CMD);
      if (state == S_CMD) begin
        x_data_send_back_addr   <= next_addr;
        x_data_send_back_length <= epoch_bytes_r;
        next_addr               <= next_addr + {32'd0, epoch_bytes_r};
      end
      if (can_read && last_in_epoch) begin
        epoch_idx   <= epoch_idx + 32'd1;
        epochs_sent <= epochs_sent + 32'd1;
      end
    end
  end

  // Data path: the FIFO answers one cycle after rd_en, so the engine select
  // is delayed to line up with its dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_r    <= 1'b0;
      rd_en_d1         <= 1'b0;
      eng_d1           <= '0;
      x_data_out       <= '0;
      x_data_out_valid <= 1'b0;
    end else begin
      almost_full_r    <= x_data_out_almost_full;
      rd_en_d1         <= can_read;
      eng_d1           <= eng;
      x_data_out       <= x_to_mem_rd_data[32'(eng_d1) * DATA_WIDTH +: DATA_WIDTH];
      x_data_out_valid <= rd_en_d1;
    end
  end

endmodule

// File: tb/tb_sgd_x_fifo_drain_to_host.sv
module tb_sgd_x_fifo_drain_to_host;
  import sgd_x_fifo_drain_to_host_pkg::*;

  localparam int E = ENGINE_NUM;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  started = 1'b0;
  logic [63:0]           addr_model = '0;
  logic [31:0]           dimension = '0;
  logic [31:0]           num_epochs = '0;
  logic [E*512-1:0]      rd_data = '0;
  logic [E-1:0]          empty_r = '1;
  logic [E-1:0]          hold_mask = '0;
  logic [E-1:0]          fifo_empty;
  logic [E-1:0]          rd_en;
  logic                  cmd_start;
  logic [63:0]           cmd_addr;
  logic [31:0]           cmd_len;
  logic [511:0]          data_out;
  logic                  data_valid;
  logic                  almost_full = 1'b0;
  logic [31:0]           epochs_sent;
  drain_state_t          state_dbg;

  always #5 clk = ~clk;

  assign fifo_empty = empty_r | hold_mask;

  sgd_x_fifo_drain_to_host dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .started                 (started),
    .addr_model              (addr_model),
    .dimension               (dimension),
    .numEpochs               (num_epochs),
    .x_to_mem_rd_data        (rd_data),
    .x_to_mem_empty          (fifo_empty),
    .x_to_mem_rd_en          (rd_en),
    .x_data_send_back_start  (cmd_start),
    .x_data_send_back_addr   (cmd_addr),
    .x_data_send_back_length (cmd_len),
    .x_data_out              (data_out),
    .x_data_out_valid        (data_valid),
    .x_data_out_almost_full  (almost_full),
    .epochs_sent             (epochs_sent),
    .state_dbg               (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO model (standard read, latency 1) ----------------
  logic [511:0] fq [E][$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < E; e++) fq[e].delete();
      empty_r <= '1;
    end else begin
      for (int e = 0; e < E; e++) begin
        if (rd_en[e] && fq[e].size() > 0) rd_data[e*512 +: 512] <= fq[e].pop_front();
        empty_r[e] <= (fq[e].size() == 0);
      end
    end
  end

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           rd_count = 0;
  int           ncmd = 0;
  logic [31:0]  obs_q[$];
  int           obs_cyc_q[$];
  int           obs_ncmd_q[$];
  logic [63:0]  cmd_addr_q[$];
  logic [31:0]  cmd_len_q[$];
  int           cmd_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      ncmd = 0;
    end else begin
      if (|rd_en) rd_count++;
      if (cmd_start) begin
        ncmd++;
        cmd_addr_q.push_back(cmd_addr);
        cmd_len_q.push_back(cmd_len);
        cmd_cyc_q.push_back(cyc);
      end
      if (data_valid) begin
        obs_q.push_back(data_out[31:0]);
        obs_cyc_q.push_back(cyc);
        obs_ncmd_q.push_back(ncmd);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  function automatic logic [31:0] tag(input int ep, input int row, input int eng, input int beat);
    return {8'(ep), 8'(row), 8'(eng), 8'(beat)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill_epoch(input int ep, input int rows);
    logic [31:0] t;
    for (int r = 0; r < rows; r++)
      for (int e = 0; e < E; e++)
        for (int b = 0; b < BEATS_PER_EN; b++) begin
          t = tag(ep, r, e, b);
          fq[e].push_back({16{t}});
          exp_q.push_back(t);
        end
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc_q.delete(); obs_ncmd_q.delete();
    cmd_addr_q.delete(); cmd_len_q.delete(); cmd_cyc_q.delete();
    rd_count = 0;
    ncmd = 0;
  endtask

  task automatic start_job(input logic [63:0] a, input logic [31:0] d, input logic [31:0] n);
    addr_model = a; dimension = d; num_epochs = n; started = 1'b1;
  endtask

  task automatic wait_state(input drain_state_t target, input int bound, input string name);
    int k = 0;
    while (state_dbg !== target && k < bound) begin cycles(1); k++; end
    checks++;
    if (state_dbg !== target) begin
      errors++;
      $display("FAIL %s: state %b after %0d cycles, expected %b", name, state_dbg, k, target);
    end
  endtask

  task automatic wait_obs(input int n, input int bound, input string name);
    int k = 0;
    while (obs_q.size() < n && k < bound) begin cycles(1); k++; end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL %s: %0d beats seen, expected at least %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic end_job(input string name);
    started = 1'b0;
    cycles(2);
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL %s_idle: state %b, expected %b", name, state_dbg, S_IDLE);
    end
  endtask

  // Compares every observed beat, in order, against the expected queue.
  task automatic score_stream(input string name);
    int n;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: %0d beats, expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: tag %h, expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    checks++; if (cmd_start !== 1'b0)   begin errors++; $display("FAIL reset_start: %b, expected 0", cmd_start); end
    checks++; if (data_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: %b, expected 0", data_valid); end
    checks++; if (rd_en !== '0)         begin errors++; $display("FAIL reset_rd_en: %b, expected 0", rd_en); end
    checks++; if (epochs_sent !== 32'd0) begin errors++; $display("FAIL reset_epochs: %0d, expected 0", epochs_sent); end
    checks++; if (cmd_addr !== 64'd0 || cmd_len !== 32'd0) begin errors++; $display("FAIL reset_cmd: addr %h len %h, expected 0 0", cmd_addr, cmd_len); end
    checks++; if (data_out !== '0)      begin errors++; $display("FAIL reset_data: %h, expected 0", data_out[31:0]); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: %b, expected %b", state_dbg, S_IDLE); end
  endtask

  task automatic test_single_epoch();
    int bad = 0;
    clear_obs();
    fill_epoch(0, 1);
    start_job(64'h1000, 32'd512, 32'd1);
    wait_state(S_END, 200, "single_end");
    cycles(4);
    checks++;
    if (cmd_addr_q.size() != 1) begin
      errors++; $display("FAIL single_cmds: %0d commands, expected 1", cmd_addr_q.size());
    end else begin
      checks++; if (cmd_addr_q[0] !== 64'h1000) begin errors++; $display("FAIL single_addr: %h, expected 1000", cmd_addr_q[0]); end
      checks++; if (cmd_len_q[0] !== 32'd2048)  begin errors++; $display("FAIL single_len: %0d, expected 2048", cmd_len_q[0]); end
    end
    foreach (obs_ncmd_q[i]) if (obs_ncmd_q[i] != 1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_order: %0d beats outside their command, expected 0", bad); end
    checks++; if (epochs_sent !== 32'd1) begin errors++; $display("FAIL single_epochs: %0d, expected 1", epochs_sent); end
    score_stream("single");
    end_job("single");
  endtask

  task automatic test_two_epochs();
    int bad = 0;
    clear_obs();
    fill_epoch(0, 2);
    fill_epoch(1, 2);
    start_job(64'h1000, 32'd1000, 32'd2);
    wait_state(S_END, 400, "two_end");
    cycles(4);
    checks++;
    if (cmd_addr_q.size() != 2) begin
      errors++; $display("FAIL two_cmds: %0d commands, expected 2", cmd_addr_q.size());
    end else begin
      checks++; if (cmd_addr_q[0] !== 64'h1000) begin errors++; $display("FAIL two_addr0: %h, expected 1000", cmd_addr_q[0]); end
      checks++; if (cmd_addr_q[1] !== 64'h2000) begin errors++; $display("FAIL two_addr1: %h, expected 2000", cmd_addr_q[1]); end
      checks++; if (cmd_len_q[0] !== 32'd4096 || cmd_len_q[1] !== 32'd4096) begin
        errors++; $display("FAIL two_len: %0d %0d, expected 4096 4096", cmd_len_q[0], cmd_len_q[1]);
      end
      if (obs_cyc_q.size() >= 64) begin
        checks++;
        if (cmd_cyc_q[1] <= obs_cyc_q[63]) begin
          errors++; $display("FAIL two_cmd_gap: second command at cycle %0d, last epoch-0 beat at %0d", cmd_cyc_q[1], obs_cyc_q[63]);
        end
      end
    end
    foreach (obs_ncmd_q[i]) if (obs_ncmd_q[i] != 1 + i / 64) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL two_order: %0d beats outside their command, expected 0", bad); end
    checks++; if (epochs_sent !== 32'd2) begin errors++; $display("FAIL two_epochs: %0d, expected 2", epochs_sent); end
    score_stream("two");
    end_job("two");
  endtask

  task automatic test_backpressure();
    int rd0, v_a;
    clear_obs();
    fill_epoch(0, 1);
    start_job(64'h1000, 32'd512, 32'd1);
    wait_obs(10, 200, "bp_pre");
    almost_full = 1'b1;
    rd0 = rd_count;
    cycles(4);
    v_a = obs_q.size();
    cycles(16);
    checks++; if (rd_count - rd0 > 2) begin errors++; $display("FAIL bp_reads: %0d reads after rise, expected <= 2", rd_count - rd0); end
    checks++; if (obs_q.size() != v_a) begin errors++; $display("FAIL bp_hold: %0d beats during hold, expected 0", obs_q.size() - v_a); end
    almost_full = 1'b0;
    wait_state(S_END, 200, "bp_end");
    cycles(4);
    score_stream("bp");
    end_job("bp");
  endtask

  task automatic test_empty_stall();
    int k = 0;
    int bad = 0;
    clear_obs();
    fill_epoch(0, 1);
    hold_mask = E'(1) << 3;
    start_job(64'h1000, 32'd512, 32'd1);
    while (rd_count < 12 && k < 200) begin cycles(1); k++; end
    repeat (10) begin cycles(1); if (rd_en !== '0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_rd_en: %0d cycles with a read, expected 0", bad); end
    checks++; if (rd_count != 12) begin errors++; $display("FAIL stall_reads: %0d reads, expected 12", rd_count); end
    hold_mask = '0;
    wait_state(S_END, 200, "stall_end");
    cycles(4);
    checks++;
    if (obs_q.size() < 13 || obs_q[12] !== tag(0, 0, 3, 0)) begin
      errors++; $display("FAIL stall_resume: beat 12 tag %h, expected %h", (obs_q.size() > 12) ? obs_q[12] : 32'hffffffff, tag(0, 0, 3, 0));
    end
    score_stream("stall");
    end_job("stall");
  endtask

  task automatic test_degenerate();
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      if (t == 0) start_job(64'h1000, 32'd512, 32'd0);
      else        start_job(64'h1000, 32'd0, 32'd3);
      wait_state(S_END, 50, "degen_end");
      cycles(4);
      checks++; if (cmd_addr_q.size() != 0) begin errors++; $display("FAIL degen%0d_cmds: %0d commands, expected 0", t, cmd_addr_q.size()); end
      checks++; if (obs_q.size() != 0)      begin errors++; $display("FAIL degen%0d_beats: %0d beats, expected 0", t, obs_q.size()); end
      checks++; if (epochs_sent !== 32'd0)  begin errors++; $display("FAIL degen%0d_epochs: %0d, expected 0", t, epochs_sent); end
      end_job("degen");
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    fill_epoch(0, 1);
    start_job(64'h1000, 32'd512, 32'd1);
    wait_obs(5, 200, "rst_pre");
    #3 rst_n = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0 || cmd_start !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: valid %b start %b, expected 0 0", data_valid, cmd_start); end
    checks++; if (rd_en !== '0) begin errors++; $display("FAIL rst_mid_rd_en: %b, expected 0", rd_en); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_mid_data: %h, expected 0", data_out[31:0]); end
    checks++; if (cmd_addr !== 64'd0) begin errors++; $display("FAIL rst_mid_addr: %h, expected 0", cmd_addr); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_mid_state: %b, expected %b", state_dbg, S_IDLE); end
    started = 1'b0;
    cycles(3);
    exp_q.delete();
    clear_obs();
    rst_n = 1'b1;
    cycles(1);
    fill_epoch(0, 1);
    start_job(64'h8000, 32'd512, 32'd1);
    wait_state(S_END, 200, "rst_end");
    cycles(4);
    checks++;
    if (cmd_addr_q.size() != 1 || cmd_addr_q[0] !== 64'h8000) begin
      errors++; $display("FAIL rst_new_cmd: %0d commands, first addr %h, expected 1 at 8000", cmd_addr_q.size(), (cmd_addr_q.size() > 0) ? cmd_addr_q[0] : 64'd0);
    end
    checks++;
    if (obs_ncmd_q.size() == 0 || obs_ncmd_q[0] != 1) begin
      errors++; $display("FAIL rst_new_first: first beat after %0d commands, expected 1", (obs_ncmd_q.size() > 0) ? obs_ncmd_q[0] : 0);
    end
    score_stream("rst_new");
    end_job("rst_new");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_epoch();
    test_two_epochs();
    test_backpressure();
    test_empty_stall();
    test_degenerate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
